// File: rtl/hstl_rx_pkg.sv
// Shared definitions for the HSTL class-II receive capture path: default
// parameters, the event record layout and a constant-width helper.
package hstl_rx_pkg;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_FILT_LEN    = 4;
  localparam int DEF_TS_W        = 16;
  localparam int DEF_FIFO_DEPTH  = 4;

  // Event record at the default timestamp width; modules with a different
  // TS_W declare the same {rise, ts} layout locally.
  typedef struct packed {
    logic                rise;
    logic [DEF_TS_W-1:0] ts;
  } hstl_evt_t;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  function automatic int min1_clog2(input int value);
    return (clog2(value) < 1) ? 1 : clog2(value);
  endfunction

endpackage

// File: rtl/hstl_rx_evt_fifo.sv
// First-word-fall-through event FIFO: the head word is visible whenever the
// FIFO is non-empty; a push into a full FIFO is accepted only alongside a pop.
module hstl_rx_evt_fifo
  import hstl_rx_pkg::*;
#(
  parameter int W     = DEF_TS_W + 1,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          do_push;
  logic          do_pop;

  always_comb begin
    empty_o  = (wr_ptr_q == rd_ptr_q);
    full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    head_o   = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/ibuf_hstl_ii_rx_capture.sv
// Pad receive capture: synchronise the asynchronous pad level, glitch-filter
// it into O, and queue timestamped edge events for the fabric to drain.
module ibuf_hstl_ii_rx_capture
  import hstl_rx_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILT_LEN    = DEF_FILT_LEN,
  parameter int TS_W        = DEF_TS_W,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            I,
  input  logic            EN,
  output logic            O,
  output logic            EVT_VALID,
  input  logic            EVT_READY,
  output logic            EVT_RISE,
  output logic [TS_W-1:0] EVT_TS,
  output logic            OVF,
  input  logic            OVF_CLR
);

  localparam int CNT_W = min1_clog2(FILT_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

  typedef struct packed {
    logic            rise;
    logic [TS_W-1:0] ts;
  } evt_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   o_q, o_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [TS_W-1:0]        ts_q, ts_d;
  logic                   ovf_q, ovf_d;

  logic                   s;
  logic                   flip;
  logic                   push;
  logic                   pop;
  logic                   drop;
  evt_t                   push_evt;
  evt_t                   head_evt;
  logic                   fifo_full;
  logic                   fifo_empty;

  always_comb begin
    s      = sync_q[SYNC_STAGES-1];
    sync_d = {sync_q[SYNC_STAGES-2:0], I};

    // O only moves after FILT_LEN consecutive samples disagree with it.
    o_d   = o_q;
    cnt_d = cnt_q;
    flip  = 1'b0;
    if (s == o_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      o_d   = s;
      cnt_d = '0;
      flip  = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    ts_d = EN ? ts_q + TS_W'(1) : ts_q;

    push          = flip && EN;
    push_evt.rise = s;
    push_evt.ts   = ts_q;
    pop           = EVT_READY && !fifo_empty;
    // Full implies non-empty, so a push is lost only when no pop frees a slot.
    drop          = push && fifo_full && !pop;

    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (OVF_CLR) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q <= '0;
      o_q    <= 1'b0;
      cnt_q  <= '0;
      ts_q   <= '0;
      ovf_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      o_q    <= o_d;
      cnt_q  <= cnt_d;
      ts_q   <= ts_d;
      ovf_q  <= ovf_d;
    end
  end

  hstl_rx_evt_fifo #(
    .W     (TS_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_evt_fifo (
    .clk_i       (CLK),
    .rst_ni      (RST_N),
    .push_i      (push),
    .push_data_i (push_evt),
    .pop_i       (pop),
    .head_o      (head_evt),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign O         = o_q;
  assign OVF       = ovf_q;
  assign EVT_VALID = !fifo_empty;
  assign EVT_RISE  = head_evt.rise;
  assign EVT_TS    = head_evt.ts;

endmodule

// File: tb/tb_ibuf_hstl_ii_rx_capture.sv
// Bench for the pad receive capture: directed scenarios plus randomized pad
// activity against a queue-based reference model of the filter and event FIFO.
module tb_ibuf_hstl_ii_rx_capture;

  localparam int SYNC  = 2;
  localparam int FILT  = 4;
  localparam int TS_W  = 16;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic            rst_n = 1'b0;
  logic            i_pad = 1'b0;
  logic            en = 1'b0;
  logic            evt_ready = 1'b0;
  logic            ovf_clr = 1'b0;
  logic            o;
  logic            evt_valid;
  logic            evt_rise;
  logic [TS_W-1:0] evt_ts;
  logic            ovf;

  logic            rst4_n = 1'b0;
  logic            i4 = 1'b0;
  logic            en4 = 1'b0;
  logic            ready4 = 1'b0;
  logic            clr4 = 1'b0;
  logic            o4;
  logic            valid4;
  logic            rise4;
  logic [3:0]      ts4;
  logic            ovf4;

  int checks   = 0;
  int failures = 0;

  ibuf_hstl_ii_rx_capture dut (
    .CLK(CLK), .RST_N(rst_n), .I(i_pad), .EN(en), .O(o),
    .EVT_VALID(evt_valid), .EVT_READY(evt_ready), .EVT_RISE(evt_rise),
    .EVT_TS(evt_ts), .OVF(ovf), .OVF_CLR(ovf_clr)
  );

  ibuf_hstl_ii_rx_capture #(.TS_W(4)) dut4 (
    .CLK(CLK), .RST_N(rst4_n), .I(i4), .EN(en4), .O(o4),
    .EVT_VALID(valid4), .EVT_READY(ready4), .EVT_RISE(rise4),
    .EVT_TS(ts4), .OVF(ovf4), .OVF_CLR(clr4)
  );

  // ---------------- reference model ----------------
  logic [TS_W:0]   exp_q[$];
  bit              i_hist[$];
  bit              s_win[$];
  bit              m_o;
  bit              m_ovf;
  logic [TS_W-1:0] m_ts;

  always @(posedge CLK or negedge rst_n) begin
    bit s, flip, pop, push, drop;
    if (!rst_n) begin
      exp_q.delete();
      i_hist.delete();
      repeat (SYNC) i_hist.push_back(1'b0);
      s_win.delete();
      m_o   = 1'b0;
      m_ovf = 1'b0;
      m_ts  = '0;
    end else begin
      i_hist.push_back(i_pad);
      s = i_hist.pop_front();
      s_win.push_back(s);
      if (s_win.size() > FILT) void'(s_win.pop_front());
      flip = (s_win.size() == FILT);
      foreach (s_win[k]) if (s_win[k] == m_o) flip = 1'b0;
      pop  = (exp_q.size() != 0) && evt_ready;
      push = flip && en;
      drop = push && (exp_q.size() == DEPTH) && !pop;
      if (pop) void'(exp_q.pop_front());
      if (push && !drop) exp_q.push_back({s, m_ts});
      if (drop) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      if (flip) m_o = s;
      if (en) m_ts = m_ts + 1'b1;
    end
  end

  // ---------------- scoreboard ----------------
  bit sb_on = 1'b0;

  always @(negedge CLK) begin
    logic [TS_W:0] head;
    bit            m_valid;
    if (sb_on) begin
      m_valid = (exp_q.size() != 0);
      head    = m_valid ? exp_q[0] : '0;
      checks++;
      if ({o, evt_valid, evt_rise, evt_ts, ovf} !== {m_o, m_valid, head, m_ovf}) begin
        failures++;
        $display("FAIL scoreboard t=%0t got o=%b v=%b r=%b ts=%0d ovf=%b expected o=%b v=%b r=%b ts=%0d ovf=%b",
                 $time, o, evt_valid, evt_rise, evt_ts, ovf,
                 m_o, m_valid, head[TS_W], head[TS_W-1:0], m_ovf);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; i_pad = 1'b1; en = 1'b1; evt_ready = 1'b0; ovf_clr = 1'b0;
    tick();
    sb_on = 1'b1;
    repeat (2) tick();
    checks++;
    if (o !== 1'b0 || evt_valid !== 1'b0 || ovf !== 1'b0 || evt_ts !== '0) begin
      failures++;
      $display("FAIL reset_state got o=%b v=%b ovf=%b ts=%0d expected all 0", o, evt_valid, ovf, evt_ts);
    end
    rst_n = 1'b1;
    repeat (5) tick();
    checks++;
    if (o !== 1'b0) begin
      failures++;
      $display("FAIL o_before_edge6 got %b expected 0", o);
    end
    tick();
    checks++;
    if (o !== 1'b1 || evt_valid !== 1'b1 || evt_rise !== 1'b1 || evt_ts !== 16'd5) begin
      failures++;
      $display("FAIL first_event got o=%b v=%b r=%b ts=%0d expected o=1 v=1 r=1 ts=5", o, evt_valid, evt_rise, evt_ts);
    end
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    checks++;
    if (evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL first_pop got v=%b expected 0", evt_valid);
    end
  endtask

  task automatic test_glitch();
    bit saw;
    logic [TS_W-1:0] t_rise;
    i_pad = 1'b0; evt_ready = 1'b1;
    repeat (10) tick();
    evt_ready = 1'b0;
    i_pad = 1'b1;
    repeat (3) tick();
    i_pad = 1'b0;
    saw = 1'b0;
    repeat (10) begin tick(); if (o) saw = 1'b1; end
    checks++;
    if (saw || evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL glitch_short got saw_high=%b v=%b expected 0 0", saw, evt_valid);
    end
    i_pad = 1'b1;
    repeat (4) tick();
    i_pad = 1'b0;
    saw = 1'b0;
    repeat (12) begin tick(); if (o) saw = 1'b1; end
    checks++;
    if (!saw || o !== 1'b0 || evt_valid !== 1'b1 || evt_rise !== 1'b1) begin
      failures++;
      $display("FAIL glitch_pulse got saw_high=%b o=%b v=%b r=%b expected 1 0 1 1", saw, o, evt_valid, evt_rise);
    end
    t_rise = evt_ts;
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    checks++;
    if (evt_valid !== 1'b1 || evt_rise !== 1'b0 || (evt_ts - t_rise) !== 16'd4) begin
      failures++;
      $display("FAIL glitch_fall got v=%b r=%b dts=%0d expected 1 0 4", evt_valid, evt_rise, evt_ts - t_rise);
    end
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    checks++;
    if (evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL glitch_drain got v=%b expected 0", evt_valid);
    end
  endtask

  task automatic test_overflow();
    evt_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      i_pad = ~i_pad;
      repeat (6) tick();
    end
    checks++;
    if (evt_valid !== 1'b1 || ovf !== 1'b1 || evt_rise !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set got v=%b ovf=%b r=%b expected 1 1 1", evt_valid, ovf, evt_rise);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clr got %b expected 0", ovf);
    end
    evt_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (evt_valid !== 1'b1 || evt_rise !== ((j % 2) == 0)) begin
        failures++;
        $display("FAIL ovf_drain%0d got v=%b r=%b expected v=1 r=%0d", j, evt_valid, evt_rise, (j % 2) == 0);
      end
      tick();
    end
    evt_ready = 1'b0;
    checks++;
    if (evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL ovf_empty got v=%b expected 0", evt_valid);
    end
  endtask

  task automatic test_full_push_pop();
    logic [TS_W-1:0] prev_ts;
    bit exp_rise;
    evt_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i_pad = ~i_pad;
      repeat (6) tick();
    end
    i_pad = ~i_pad;
    repeat (5) tick();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    checks++;
    if (ovf !== 1'b0 || o !== i_pad) begin
      failures++;
      $display("FAIL full_push_pop got ovf=%b o=%b expected ovf=0 o=%b", ovf, o, i_pad);
    end
    // Oldest survivor is the second edge of the run, which was a rise.
    exp_rise = 1'b1;
    prev_ts  = evt_ts - 16'd6;
    evt_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (evt_valid !== 1'b1 || evt_rise !== exp_rise || (evt_ts - prev_ts) !== 16'd6) begin
        failures++;
        $display("FAIL fpp_order%0d got v=%b r=%b dts=%0d expected v=1 r=%b dts=6",
                 j, evt_valid, evt_rise, evt_ts - prev_ts, exp_rise);
      end
      prev_ts  = evt_ts;
      exp_rise = ~exp_rise;
      tick();
    end
    evt_ready = 1'b0;
    checks++;
    if (evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL fpp_occupancy got v=%b after 4 pops expected 0", evt_valid);
    end
  endtask

  task automatic test_en_off();
    logic [TS_W-1:0] frozen;
    frozen = m_ts;
    en = 1'b0;
    i_pad = ~i_pad;
    repeat (8) tick();
    checks++;
    if (o !== i_pad || evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL en_off_edge got o=%b v=%b expected o=%b v=0", o, evt_valid, i_pad);
    end
    en = 1'b1;
    i_pad = ~i_pad;
    repeat (6) tick();
    checks++;
    if (o !== i_pad || evt_valid !== 1'b1 || evt_rise !== i_pad || evt_ts !== frozen + 16'd5) begin
      failures++;
      $display("FAIL en_resume got o=%b v=%b r=%b ts=%0d expected o=%b v=1 r=%b ts=%0d",
               o, evt_valid, evt_rise, evt_ts, i_pad, i_pad, frozen + 16'd5);
    end
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int c = 0; c < 2500; c++) begin
      if (hold == 0) begin
        i_pad = $urandom_range(0, 1);
        hold  = $urandom_range(1, 8);
      end
      hold--;
      en        = ($urandom_range(0, 9) != 0);
      evt_ready = ($urandom_range(0, 3) == 0);
      ovf_clr   = ($urandom_range(0, 19) == 0);
      tick();
    end
    en = 1'b1; ovf_clr = 1'b0; evt_ready = 1'b1;
    repeat (16) tick();
    evt_ready = 1'b0;
    checks++;
    if (evt_valid !== 1'b0 || o !== i_pad) begin
      failures++;
      $display("FAIL random_settle got v=%b o=%b expected v=0 o=%b", evt_valid, o, i_pad);
    end
  endtask

  task automatic test_ts_wrap();
    int k;
    logic [3:0] exp_ts4;
    en4 = 1'b1; i4 = 1'b0; ready4 = 1'b0; clr4 = 1'b0;
    rst4_n = 1'b1;
    repeat (20) tick();
    i4 = 1'b1;
    k = 0;
    while (!valid4 && k < 20) begin
      tick();
      k++;
    end
    exp_ts4 = 4'((20 + SYNC + FILT - 1) % 16);
    checks++;
    if (k != SYNC + FILT || valid4 !== 1'b1 || rise4 !== 1'b1 || ts4 !== exp_ts4) begin
      failures++;
      $display("FAIL ts_wrap got cycles=%0d v=%b r=%b ts=%0d expected cycles=%0d v=1 r=1 ts=%0d",
               k, valid4, rise4, ts4, SYNC + FILT, exp_ts4);
    end
    i4 = 1'b0;
    repeat (8) tick();
    checks++;
    if (valid4 !== 1'b1 || rise4 !== 1'b1 || o4 !== 1'b0) begin
      failures++;
      $display("FAIL ts_wrap_two got v=%b r=%b o=%b expected 1 1 0", valid4, rise4, o4);
    end
    #2 rst4_n = 1'b0;
    #1;
    checks++;
    if (valid4 !== 1'b0 || ts4 !== 4'd0 || rise4 !== 1'b0 || ovf4 !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got v=%b ts=%0d r=%b ovf=%b expected all 0", valid4, ts4, rise4, ovf4);
    end
    @(negedge CLK);
    rst4_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (valid4 !== 1'b0 || o4 !== 1'b0) begin
      failures++;
      $display("FAIL post_reset got v=%b o=%b expected 0 0", valid4, o4);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_glitch();
    test_overflow();
    test_full_push_pop();
    test_en_off();
    test_random();
    test_ts_wrap();
    sb_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
